psd_window_integrator: RTL
==========================

Name: psd_window_integrator

Overview:
- Parametrised pulse-shape-discrimination integrator for the digitiser datapath.
- Sits downstream of the baseline tracker. On a trigger, it counts valid samples, skips a programmable pre-window, then accumulates either squared or absolute baseline-subtracted amplitude over a programmable window.
- Presents the result with a valid/ready handshake, then re-arms automatically for the next pulse.
- Replaces the fixed-window, single-shot discrimination-parameter block.

Parameters:
- DATA_W, 20, sample and baseline width (unsigned).
- CNT_W, 10, sample-index counter width; maximum window end is 2^CNT_W-1.
- ACC_W, 48, accumulator/result width; must be at least 2*DATA_W+1.

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- sample_valid  in  1  sample/baseline qualify strobe; only qualified cycles advance the index
- sample  in  DATA_W  ADC sample
- baseline  in  DATA_W  current baseline estimate
- trigger  in  1  pulse-start strobe; honoured only in IDLE
- win_start  in  CNT_W  first integrated sample index (index 0 = first valid sample at/after trigger)
- win_end  in  CNT_W  exclusive end index
- mode  in  1  0 = sum of squares, 1 = sum of absolute differences
- out_ready  in  1  consumer accepts result
- result  out  ACC_W  accumulated parameter
- result_valid  out  1  result held and stable
- busy  out  1  high in DELAY, INTEGRATE and HOLD
- overflow  out  1  accumulator saturated during this pulse; valid with result

Behaviour:
- Reset: state IDLE; result=0, result_valid=0, busy=0, overflow=0; index and accumulator cleared.
- The reset is asynchronous and may occur mid-pulse: it aborts the pulse immediately and drops any held result.
- Configuration latch: win_start, win_end and mode are captured on the trigger cycle. Later changes have no effect until the next trigger.
- Amplitude: signed difference of sample minus baseline, DATA_W+1 bits. In mode 0 it is squared; in mode 1 its magnitude is taken. The value is zero-extended to ACC_W.
- Accumulate: saturating add. On saturation the accumulator holds all-ones and the sticky overflow flag is set.
- IDLE:
  - trigger=1: clear index and accumulator, latch config, go to DELAY.
  - If sample_valid is also high on the trigger cycle, that sample is index 0.
- DELAY:
  - Each valid sample increments the index.
  - When the index of the current valid sample equals win_start, that sample is accumulated and the state moves to INTEGRATE.
- INTEGRATE:
  - Each valid sample is accumulated.
  - When the accumulated sample index equals win_end-1, result is registered on that edge and the state moves to HOLD.
  - result_valid rises the cycle after the last window sample is accepted (latency 1).
- Empty window (win_end <= win_start): on the trigger cycle, go directly to HOLD with result=0 and overflow=0.
- HOLD:
  - result_valid=1; result and overflow are stable.
  - When out_ready=1, the transfer completes that edge: result_valid drops and the state returns to IDLE.
  - A trigger on the handshake cycle is ignored; re-arm needs one IDLE cycle.
- Triggers during DELAY, INTEGRATE or HOLD are ignored, with no queueing.
- Samples arriving during HOLD are dropped.
- sample_valid low stalls the index and the accumulator with no other effect.
- Index counter does not wrap: because win_end is at most 2^CNT_W-1, the window always closes before wrap.

Optional Feature:
- Macro: PSD_LONG_INTEGRAL_EN.
- Defined:
  - Adds output port result_long (ACC_W) and a second saturating accumulator covering indices 0 through win_end-1, independent of win_start.
  - result_long is registered, reset and handshaken together with result.
  - overflow is the OR of both accumulators' saturation flags.
- Undefined: no port, no second accumulator; behaviour is exactly as above.

Decomposition:
- Package psd_pkg contains:
  - state enum (IDLE, DELAY, INTEGRATE, HOLD)
  - mode constants MODE_SQUARE=0 and MODE_ABS=1
  - default width constants
- Sub-module psd_sat_accumulator contains:
  - amplitude, square/abs and saturating-add datapath
  - sticky overflow flag and clear/enable inputs
  - instantiated once, or twice with PSD_LONG_INTEGRAL_EN

Test Plan:
- Basic square:
  - Stimulus: baseline=100, samples 100+k at index k, win_start=2, win_end=5, mode=0, out_ready=1.
  - Required: result=4+9+16=29, result_valid high one cycle, busy falls the following cycle.
- Negative and abs:
  - Stimulus: baseline=1000, samples 990 at indices 0..3, window [0,4).
  - Required: mode 0 gives 400; mode 1 gives 40.
- Stall and backpressure:
  - Stimulus: sample_valid toggling 1010..., out_ready low for 5 cycles after completion.
  - Required: same result as the contiguous case; result held stable for 5 cycles; a trigger pulsed during HOLD is ignored.
- Empty window:
  - Stimulus: win_start=7, win_end=7.
  - Required: result_valid the next cycle with result=0, overflow=0.
- Saturation:
  - Stimulus: ACC_W=41, DATA_W=20, sample=2^20-1, baseline=0, window [0,4).
  - Required: result=2^41-1, overflow=1. The next pulse with small amplitudes gives overflow=0.
- Reset mid-INTEGRATE:
  - Stimulus: assert nrst low at index 3 of window [0,10).
  - Required: all outputs 0 immediately. A fresh trigger after release yields a correct, uncontaminated result.

Source files
------------

// File: rtl/psd_pkg.sv
// Shared types and default widths for the pulse-shape-discrimination integrator.
package psd_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DELAY     = 2'd1,
    INTEGRATE = 2'd2,
    HOLD      = 2'd3
  } state_e;

  localparam logic MODE_SQUARE = 1'b0;
  localparam logic MODE_ABS    = 1'b1;

  localparam int DEF_DATA_W = 20;
  localparam int DEF_CNT_W  = 10;
  localparam int DEF_ACC_W  = 48;

endpackage

// File: rtl/psd_sat_accumulator.sv
// Baseline-subtracted amplitude (squared or magnitude) feeding a saturating
// accumulator with a sticky saturation flag; exposes its next-state values.
module psd_sat_accumulator
  import psd_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [DATA_W-1:0] sample_i,
  input  logic [DATA_W-1:0] baseline_i,
  input  logic              mode_i,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [ACC_W-1:0]  acc_d_o,
  output logic              sat_d_o
);

  logic [ACC_W-1:0]      acc_q;
  logic                  sat_q;
  logic signed [DATA_W:0] diff;
  logic [DATA_W:0]       mag;
  logic [2*DATA_W:0]     mag_x;
  logic [2*DATA_W:0]     sq;
  logic [ACC_W-1:0]      amp;
  logic [ACC_W-1:0]      base;
  logic                  sat_base;
  logic [ACC_W:0]        sum;

  assign diff  = $signed({1'b0, sample_i}) - $signed({1'b0, baseline_i});
  assign mag   = diff[DATA_W] ? -diff : diff;
  // |diff| <= 2^DATA_W-1, so its square always fits in 2*DATA_W+1 bits.
  assign mag_x = {{DATA_W{1'b0}}, mag};
  assign sq    = mag_x * mag_x;

  always_comb begin
    amp = '0;
    if (mode_i == MODE_ABS) amp[DATA_W:0]   = mag;
    else                    amp[2*DATA_W:0] = sq;
  end

  // A clear on the same cycle as an enable starts the new sum from zero.
  assign base     = clr_i ? '0 : acc_q;
  assign sat_base = clr_i ? 1'b0 : sat_q;
  assign sum      = {1'b0, base} + {1'b0, amp};

  always_comb begin
    acc_d_o = base;
    sat_d_o = sat_base;
    if (en_i) begin
      if (sum[ACC_W]) begin
        acc_d_o = '1;
        sat_d_o = 1'b1;
      end else begin
        acc_d_o = sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d_o;
      sat_q <= sat_d_o;
    end
  end

endmodule

// File: rtl/psd_window_integrator.sv
// Triggered windowed PSD integrator with valid/ready result hand-off.
// Optional PSD_LONG_INTEGRAL_EN adds result_long, an integral over [0, win_end).
module psd_window_integrator
  import psd_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] baseline,
  input  logic              trigger,
  input  logic [CNT_W-1:0]  win_start,
  input  logic [CNT_W-1:0]  win_end,
  input  logic              mode,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid,
  output logic              busy,
  output logic              overflow
`ifdef PSD_LONG_INTEGRAL_EN
  ,
  output logic [ACC_W-1:0]  result_long
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] ws_q, ws_d;
  logic [CNT_W-1:0] we_q, we_d;
  logic             mode_q, mode_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;

  logic [CNT_W-1:0] eff_ws, eff_we, cur_idx;
  logic             eff_mode;
  logic             active, take, in_win, last, acc_clr;
  logic [ACC_W-1:0] acc_d;
  logic             sat_d, sat_any_d;

  // Control view of the current cycle; on the trigger cycle the live config
  // applies so a sample arriving with the trigger is handled as index 0.
  always_comb begin
    eff_ws   = ws_q;
    eff_we   = we_q;
    eff_mode = mode_q;
    cur_idx  = idx_q;
    active   = 1'b0;
    acc_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          eff_ws   = win_start;
          eff_we   = win_end;
          eff_mode = mode;
          cur_idx  = '0;
          acc_clr  = 1'b1;
          active   = (win_end > win_start);
        end
      end
      DELAY, INTEGRATE: active = 1'b1;
      default: active = 1'b0;
    endcase
    take   = active & sample_valid;
    in_win = (cur_idx >= eff_ws);
    last   = (cur_idx == eff_we - CNT_W'(1));
  end

  psd_sat_accumulator #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_acc (
    .clk        (clk),
    .nrst       (nrst),
    .sample_i   (sample),
    .baseline_i (baseline),
    .mode_i     (eff_mode),
    .clr_i      (acc_clr),
    .en_i       (take & in_win),
    .acc_d_o    (acc_d),
    .sat_d_o    (sat_d)
  );

`ifdef PSD_LONG_INTEGRAL_EN
  logic [ACC_W-1:0] acc_long_d, result_long_q, result_long_d;
  logic             sat_long_d;

  psd_sat_accumulator #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_acc_long (
    .clk        (clk),
    .nrst       (nrst),
    .sample_i   (sample),
    .baseline_i (baseline),
    .mode_i     (eff_mode),
    .clr_i      (acc_clr),
    .en_i       (take),
    .acc_d_o    (acc_long_d),
    .sat_d_o    (sat_long_d)
  );

  assign sat_any_d = sat_d | sat_long_d;

  always_comb begin
    result_long_d = result_long_q;
    if (state_q == IDLE && trigger) result_long_d = '0;
    if (take && last)               result_long_d = acc_long_d;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) result_long_q <= '0;
    else       result_long_q <= result_long_d;
  end

  assign result_long = result_long_q;
`else
  assign sat_any_d = sat_d;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ws_d     = ws_q;
    we_d     = we_q;
    mode_d   = mode_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          ws_d     = win_start;
          we_d     = win_end;
          mode_d   = mode;
          idx_d    = '0;
          result_d = '0;
          ovf_d    = 1'b0;
          state_d  = (win_end > win_start) ? DELAY : HOLD;
        end
      end
      HOLD:    if (out_ready) state_d = IDLE;
      default: ;
    endcase
    if (take) begin
      idx_d = cur_idx + CNT_W'(1);
      if (in_win) state_d = INTEGRATE;
      if (last) begin
        state_d  = HOLD;
        result_d = acc_d;
        ovf_d    = sat_any_d;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      ws_q     <= '0;
      we_q     <= '0;
      mode_q   <= MODE_SQUARE;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ws_q     <= ws_d;
      we_q     <= we_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign result       = result_q;
  assign result_valid = (state_q == HOLD);
  assign busy         = (state_q != IDLE);
  assign overflow     = ovf_q;

endmodule
